// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V control logic.
// Contents: opcode constants, multicycle FSM state encodings, aluOp codes,
// ALU control codes and immediate-format codes.
// The pipelined core reuses these values, so keep the encodings stable.
package riscv_pkg;

    // Opcodes, taken from instr[6:0]
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    // Multicycle FSM states. Codes 11-15 are unused and recover to FETCH.
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10
    } state_t;

    // aluOp codes, passed from the main decoder to the ALU decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU control codes
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Immediate formats
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/riscv_alu_decoder.sv
// Combinational ALU decoder. It is shared by the multicycle and pipelined cores.
// Ports:
//   i_alu_op      2  operation class: add, sub, or decode from funct fields
//   i_funct3      3  instr[14:12]
//   i_funct7b5    1  instr[30]
//   i_op5         1  instr[5]; separates R-type (1) from I-type (0)
//   o_alu_control 3  ALU operation select
module riscv_alu_decoder
    import riscv_pkg::*;
(
    input  logic [1:0] i_alu_op,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7b5,
    input  logic       i_op5,
    output logic [2:0] o_alu_control
);

    // Map aluOp and the funct fields to an ALU operation
    always_comb begin
        o_alu_control = ALU_ADD;
        case (i_alu_op)
            ALUOP_ADD: o_alu_control = ALU_ADD;
            ALUOP_SUB: o_alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (i_funct3)
                    3'b000: begin
                        // instr[30] selects sub only for R-type. An addi
                        // whose immediate sets that bit is still an add.
                        if (i_op5 && i_funct7b5) begin
                            o_alu_control = ALU_SUB;
                        end else begin
                            o_alu_control = ALU_ADD;
                        end
                    end
                    3'b010:  o_alu_control = ALU_SLT;
                    3'b110:  o_alu_control = ALU_OR;
                    3'b111:  o_alu_control = ALU_AND;
                    default: o_alu_control = ALU_ADD;
                endcase
            end
            default: o_alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/riscv_multicycle_ctrl.sv
// Multicycle control FSM for the non-pipelined RISC-V core.
// The FSM sequences the shared ALU, the unified memory and the register file
// using one Moore state per cycle. It supports LW, SW, R-type, I-type ALU,
// BEQ and JAL.
// Ports:
//   clk, reset                         clock; synchronous active-high reset
//   op, funct3, funct7b5               instruction fields from the IR
//   zero                               ALU zero flag (same cycle)
//   pcWrite, adrSrc, memWrite, irWrite datapath enables and selects
//   resultSrc, aluSrcA, aluSrcB        mux selects
//   immSrc, aluControl                 immediate format and ALU operation
//   regWrite                           register file write enable
//   instrDone                          pulse in the last state of an instruction
//   state                              current state (debug)
module riscv_multicycle_ctrl
    import riscv_pkg::*;
#(
    parameter int ENABLE_JAL = 1,
    parameter int STATE_W    = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [6:0]         op,
    input  logic [2:0]         funct3,
    input  logic               funct7b5,
    input  logic               zero,
    output logic               pcWrite,
    output logic               adrSrc,
    output logic               memWrite,
    output logic               irWrite,
    output logic [1:0]         resultSrc,
    output logic [1:0]         aluSrcA,
    output logic [1:0]         aluSrcB,
    output logic [1:0]         immSrc,
    output logic [2:0]         aluControl,
    output logic               regWrite,
    output logic               instrDone,
    output logic [STATE_W-1:0] state
);

    localparam logic JAL_EN = (ENABLE_JAL != 0);

    state_t     r_state;
    state_t     w_next_state;
    logic       w_is_memop;
    logic       w_is_jal;
    logic       w_supported;
    logic       w_state_valid;
    logic [1:0] w_alu_op;
    logic       w_pc_update;
    logic       w_branch;
    logic       w_mem_write_raw;
    logic       w_ir_write_raw;
    logic       w_reg_write_raw;
    logic       w_done_raw;

    assign w_is_memop  = (op == OP_LW) || (op == OP_SW);
    assign w_is_jal    = JAL_EN && (op == OP_JAL);
    assign w_supported = w_is_memop || (op == OP_R) || (op == OP_I) ||
                         (op == OP_BEQ) || w_is_jal;
    assign w_state_valid = (r_state <= S_BEQ);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = S_FETCH;
        case (r_state)
            S_FETCH: w_next_state = S_DECODE;
            S_DECODE: begin
                if (w_is_memop) begin
                    w_next_state = S_MEMADR;
                end else if (op == OP_R) begin
                    w_next_state = S_EXECR;
                end else if (op == OP_I) begin
                    w_next_state = S_EXECI;
                end else if (w_is_jal) begin
                    w_next_state = S_JAL;
                end else if (op == OP_BEQ) begin
                    w_next_state = S_BEQ;
                end else begin
                    w_next_state = S_FETCH;
                end
            end
            S_MEMADR: begin
                if (op == OP_LW) begin
                    w_next_state = S_MEMREAD;
                end else begin
                    w_next_state = S_MEMWRITE;
                end
            end
            S_MEMREAD:  w_next_state = S_MEMWB;
            S_MEMWB:    w_next_state = S_FETCH;
            S_MEMWRITE: w_next_state = S_FETCH;
            S_EXECR:    w_next_state = S_ALUWB;
            S_EXECI:    w_next_state = S_ALUWB;
            S_JAL:      w_next_state = S_ALUWB;
            S_ALUWB:    w_next_state = S_FETCH;
            S_BEQ:      w_next_state = S_FETCH;
            default:    w_next_state = S_FETCH;
        endcase
    end

    // Moore output decode. Each state sets only the outputs it uses.
    always_comb begin
        w_pc_update     = 1'b0;
        w_branch        = 1'b0;
        w_mem_write_raw = 1'b0;
        w_ir_write_raw  = 1'b0;
        w_reg_write_raw = 1'b0;
        w_done_raw      = 1'b0;
        w_alu_op        = ALUOP_ADD;
        adrSrc          = 1'b0;
        resultSrc       = 2'b00;
        aluSrcA         = 2'b00;
        aluSrcB         = 2'b00;
        case (r_state)
            S_FETCH: begin
                w_ir_write_raw = 1'b1;
                aluSrcB        = 2'b10;
                resultSrc      = 2'b10;
                w_pc_update    = 1'b1;
            end
            S_DECODE: begin
                // The ALU precomputes oldPC + imm as a possible branch or jump target
                aluSrcA    = 2'b01;
                aluSrcB    = 2'b01;
                w_done_raw = ~w_supported;
            end
            S_MEMADR: begin
                aluSrcA = 2'b10;
                aluSrcB = 2'b01;
            end
            S_MEMREAD: begin
                adrSrc = 1'b1;
            end
            S_MEMWB: begin
                resultSrc       = 2'b01;
                w_reg_write_raw = 1'b1;
                w_done_raw      = 1'b1;
            end
            S_MEMWRITE: begin
                adrSrc          = 1'b1;
                w_mem_write_raw = 1'b1;
                w_done_raw      = 1'b1;
            end
            S_EXECR: begin
                aluSrcA  = 2'b10;
                w_alu_op = ALUOP_FUNCT;
            end
            S_EXECI: begin
                aluSrcA  = 2'b10;
                aluSrcB  = 2'b01;
                w_alu_op = ALUOP_FUNCT;
            end
            S_JAL: begin
                // The ALU computes the link value oldPC + 4. The PC takes the
                // target that was left in ALUOut during DECODE.
                aluSrcA     = 2'b01;
                aluSrcB     = 2'b10;
                w_pc_update = 1'b1;
            end
            S_ALUWB: begin
                w_reg_write_raw = 1'b1;
                w_done_raw      = 1'b1;
            end
            S_BEQ: begin
                aluSrcA    = 2'b10;
                w_alu_op   = ALUOP_SUB;
                w_branch   = 1'b1;
                w_done_raw = 1'b1;
            end
            default: begin
                w_pc_update = 1'b0;
            end
        endcase
    end

    // Immediate format follows the opcode in every valid state
    always_comb begin
        immSrc = IMM_I;
        if (w_state_valid) begin
            case (op)
                OP_SW:   immSrc = IMM_S;
                OP_BEQ:  immSrc = IMM_B;
                OP_JAL:  immSrc = IMM_J;
                default: immSrc = IMM_I;
            endcase
        end else begin
            immSrc = IMM_I;
        end
    end

    riscv_alu_decoder u_alu_dec (
        .i_alu_op      (w_alu_op),
        .i_funct3      (funct3),
        .i_funct7b5    (funct7b5),
        .i_op5         (op[5]),
        .o_alu_control (aluControl)
    );

    // While reset is held, the write enables are forced low so that an
    // aborted instruction cannot commit anything.
    assign pcWrite   = ~reset & (w_pc_update | (w_branch & zero));
    assign memWrite  = ~reset & w_mem_write_raw;
    assign irWrite   = ~reset & w_ir_write_raw;
    assign regWrite  = ~reset & w_reg_write_raw;
    assign instrDone = ~reset & w_done_raw;
    assign state     = STATE_W'(r_state);

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
module tb_riscv_multicycle_ctrl;

    logic       clk;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       pcWrite, adrSrc, memWrite, irWrite, regWrite, instrDone;
    logic [1:0] resultSrc, aluSrcA, aluSrcB, immSrc;
    logic [2:0] aluControl;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [20:0] v;
        string       tag;
    } exp_t;

    exp_t exp_q[$];

    riscv_multicycle_ctrl #(.ENABLE_JAL(1), .STATE_W(4)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .pcWrite(pcWrite), .adrSrc(adrSrc), .memWrite(memWrite),
        .irWrite(irWrite), .resultSrc(resultSrc), .aluSrcA(aluSrcA),
        .aluSrcB(aluSrcB), .immSrc(immSrc), .aluControl(aluControl),
        .regWrite(regWrite), .instrDone(instrDone), .state(state)
    );

    always #5 clk = ~clk;

    // Expected outputs, built from the per-state output table.
    // Packing: {state, pcWrite, adrSrc, memWrite, irWrite, resultSrc,
    //           aluSrcA, aluSrcB, immSrc, aluControl, regWrite, instrDone}
    function automatic logic [20:0] exp_for(input logic [3:0] st, input logic [6:0] o,
                                            input logic [2:0] f3, input logic f7,
                                            input logic z, input logic rst);
        logic pcupd = 1'b0, br = 1'b0, adr = 1'b0, memw = 1'b0, irw = 1'b0;
        logic regw = 1'b0, done = 1'b0, pcw, known;
        logic [1:0] rs = 2'b00, sa = 2'b00, sb = 2'b00, imm = 2'b00, aop = 2'b00;
        logic [2:0] ac;
        known = (o == 7'b0000011) || (o == 7'b0100011) || (o == 7'b0110011) ||
                (o == 7'b0010011) || (o == 7'b1100011) || (o == 7'b1101111);
        case (st)
            4'd0:  begin irw = 1'b1; sb = 2'b10; rs = 2'b10; pcupd = 1'b1; end
            4'd1:  begin sa = 2'b01; sb = 2'b01; done = ~known; end
            4'd2:  begin sa = 2'b10; sb = 2'b01; end
            4'd3:  begin adr = 1'b1; end
            4'd4:  begin rs = 2'b01; regw = 1'b1; done = 1'b1; end
            4'd5:  begin adr = 1'b1; memw = 1'b1; done = 1'b1; end
            4'd6:  begin sa = 2'b10; aop = 2'b10; end
            4'd7:  begin regw = 1'b1; done = 1'b1; end
            4'd8:  begin sa = 2'b10; sb = 2'b01; aop = 2'b10; end
            4'd9:  begin sa = 2'b01; sb = 2'b10; pcupd = 1'b1; end
            4'd10: begin sa = 2'b10; aop = 2'b01; br = 1'b1; done = 1'b1; end
            default: begin end
        endcase
        if (st <= 4'd10) begin
            case (o)
                7'b0100011: imm = 2'b01;
                7'b1100011: imm = 2'b10;
                7'b1101111: imm = 2'b11;
                default:    imm = 2'b00;
            endcase
        end
        if (aop == 2'b00)      ac = 3'b000;
        else if (aop == 2'b01) ac = 3'b001;
        else begin
            case (f3)
                3'b000:  ac = (o[5] & f7) ? 3'b001 : 3'b000;
                3'b010:  ac = 3'b101;
                3'b110:  ac = 3'b011;
                3'b111:  ac = 3'b010;
                default: ac = 3'b000;
            endcase
        end
        pcw = pcupd | (br & z);
        if (rst) begin
            pcw = 1'b0; irw = 1'b0; memw = 1'b0; regw = 1'b0; done = 1'b0;
        end
        return {st, pcw, adr, memw, irw, rs, sa, sb, imm, ac, regw, done};
    endfunction

    task automatic push(input string tag, input logic [3:0] st);
        exp_t e;
        e.v   = exp_for(st, op, funct3, funct7b5, zero, reset);
        e.tag = $sformatf("%s_s%0d", tag, st);
        exp_q.push_back(e);
    endtask

    task automatic chk();
        exp_t e;
        logic [20:0] obs;
        obs = {state, pcWrite, adrSrc, memWrite, irWrite, resultSrc, aluSrcA,
               aluSrcB, immSrc, aluControl, regWrite, instrDone};
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%h expected=<entry>", obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e.v) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.v);
            end
        end
    endtask

    // Start: #1 after a posedge in FETCH. End: #1 after the edge that
    // returns to FETCH. seq holds n state codes, first code in seq[19:16].
    task automatic do_instr(input string tag, input logic [6:0] o, input logic [2:0] f3,
                            input logic f7, input logic z, input int n,
                            input logic [19:0] seq);
        op = o; funct3 = f3; funct7b5 = f7; zero = z;
        for (int k = 0; k < n; k++) push(tag, seq[19-4*k -: 4]);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        clk = 1'b0; reset = 1'b1;
        op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        push("init_reset", 4'd0);
        chk();
        @(posedge clk);
        #1;
        reset = 1'b0;

        // R add runs up to ALUWB; reset is then asserted mid-instruction
        op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b0;
        push("radd", 4'd0); push("radd", 4'd1); push("radd", 4'd6); push("radd", 4'd7);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk();
        end
        reset = 1'b1;
        #1;
        push("rst_in_s7", 4'd7);
        chk();
        for (int k = 0; k < 2; k++) begin
            push("rst_hold", 4'd0);
            @(negedge clk);
            chk();
        end
        @(posedge clk);
        #1;
        reset = 1'b0;

        do_instr("lw",     7'b0000011, 3'b010, 1'b0, 1'b0, 5, {4'd0, 4'd1, 4'd2, 4'd3, 4'd4});
        do_instr("sw",     7'b0100011, 3'b010, 1'b0, 1'b0, 4, {4'd0, 4'd1, 4'd2, 4'd5, 4'd0});
        do_instr("rsub",   7'b0110011, 3'b000, 1'b1, 1'b0, 4, {4'd0, 4'd1, 4'd6, 4'd7, 4'd0});
        do_instr("addi",   7'b0010011, 3'b000, 1'b1, 1'b0, 4, {4'd0, 4'd1, 4'd8, 4'd7, 4'd0});
        do_instr("rslt",   7'b0110011, 3'b010, 1'b0, 1'b0, 4, {4'd0, 4'd1, 4'd6, 4'd7, 4'd0});
        do_instr("andi",   7'b0010011, 3'b111, 1'b0, 1'b0, 4, {4'd0, 4'd1, 4'd8, 4'd7, 4'd0});
        do_instr("ror",    7'b0110011, 3'b110, 1'b0, 1'b0, 4, {4'd0, 4'd1, 4'd6, 4'd7, 4'd0});
        do_instr("beq_t",  7'b1100011, 3'b000, 1'b0, 1'b1, 3, {4'd0, 4'd1, 4'd10, 4'd0, 4'd0});
        do_instr("beq_nt", 7'b1100011, 3'b000, 1'b0, 1'b0, 3, {4'd0, 4'd1, 4'd10, 4'd0, 4'd0});
        do_instr("jal",    7'b1101111, 3'b000, 1'b0, 1'b0, 4, {4'd0, 4'd1, 4'd9, 4'd7, 4'd0});
        do_instr("unsup",  7'b1110011, 3'b000, 1'b0, 1'b0, 2, {4'd0, 4'd1, 4'd0, 4'd0, 4'd0});
        do_instr("tail",   7'b0000000, 3'b000, 1'b0, 1'b0, 1, {4'd0, 4'd0, 4'd0, 4'd0, 4'd0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
